// File: rtl/pixel_row_packer.sv
// Packs a serial binarised pixel stream into NrOfBits-wide row words and
// strobes each finished row, with its address, into the per-row register bank.
module pixel_row_packer #(
    parameter int NrOfBits = 28,
    parameter int NrOfRows = 28,
    parameter int RowBits  = 5
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Tick,
    input  logic                Start,
    input  logic                PixIn,
    input  logic                PixValid,
    output logic                PixReady,
    output logic [NrOfBits-1:0] Q,
    output logic                Load,
    output logic [RowBits-1:0]  RowAddr,
    output logic                Busy,
    output logic                FrameDone
);

    localparam int ColBits = (NrOfBits > 1) ? $clog2(NrOfBits) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] FILL = 2'd1;
    localparam logic [1:0] LOAD = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [ColBits-1:0] ColLast = ColBits'(NrOfBits - 1);
    localparam logic [RowBits-1:0] RowLast = RowBits'(NrOfRows - 1);

    logic [1:0]         state;
    logic [ColBits-1:0] col;
    logic               pix_accept;

    // Strobes are gated by Tick so a stalled pipeline never sees a pulse.
    always_comb begin
        PixReady   = (state == FILL) && Tick;
        Load       = (state == LOAD) && Tick;
        FrameDone  = (state == DONE) && Tick;
        Busy       = (state != IDLE);
        pix_accept = PixValid && PixReady;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state   <= IDLE;
            col     <= '0;
            RowAddr <= '0;
            Q       <= '0;
        end else if (Tick) begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        state   <= FILL;
                        col     <= '0;
                        RowAddr <= '0;
                        Q       <= '0;
                    end
                end
                FILL: begin
                    if (pix_accept) begin
                        Q[col] <= PixIn;
                        if (col == ColLast) begin
                            state <= LOAD;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                LOAD: begin
                    // Q and RowAddr stay put through DONE so the bank can re-read them.
                    if (RowAddr == RowLast) begin
                        state <= DONE;
                    end else begin
                        state   <= FILL;
                        RowAddr <= RowAddr + 1'b1;
                        col     <= '0;
                        Q       <= '0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_row_packer.sv
// Directed bench for pixel_row_packer with a 4-pixel row, 2-row frame.
module tb_pixel_row_packer;

    logic       Clock;
    logic       Reset;
    logic       Tick;
    logic       Start;
    logic       PixIn;
    logic       PixValid;
    logic       PixReady;
    logic [3:0] Q;
    logic       Load;
    logic [0:0] RowAddr;
    logic       Busy;
    logic       FrameDone;

    int n_chk  = 0;
    int n_fail = 0;
    int cycle_cnt = 0;
    int s0;

    pixel_row_packer #(
        .NrOfBits(4),
        .NrOfRows(2),
        .RowBits (1)
    ) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Tick     (Tick),
        .Start    (Start),
        .PixIn    (PixIn),
        .PixValid (PixValid),
        .PixReady (PixReady),
        .Q        (Q),
        .Load     (Load),
        .RowAddr  (RowAddr),
        .Busy     (Busy),
        .FrameDone(FrameDone)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    always @(posedge Clock) cycle_cnt <= cycle_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic push(input logic p);
        PixValid = 1'b1;
        PixIn    = p;
        #1;
        chk("push_ready", {31'd0, PixReady}, 32'd1);
        step();
    endtask

    initial begin
        Reset    = 1'b0;
        Tick     = 1'b1;
        Start    = 1'b0;
        PixIn    = 1'b0;
        PixValid = 1'b0;
        repeat (2) step();
        chk("rst_busy",  {31'd0, Busy},     32'd0);
        chk("rst_q",     {28'd0, Q},        32'd0);
        chk("rst_load",  {31'd0, Load},     32'd0);
        chk("rst_ready", {31'd0, PixReady}, 32'd0);

        // Idle after reset release
        Reset = 1'b1;
        repeat (5) begin
            step();
            chk("idle_busy",  {31'd0, Busy},      32'd0);
            chk("idle_ready", {31'd0, PixReady},  32'd0);
            chk("idle_load",  {31'd0, Load},      32'd0);
            chk("idle_done",  {31'd0, FrameDone}, 32'd0);
        end
        chk("idle_q",    {28'd0, Q},       32'd0);
        chk("idle_addr", {31'd0, RowAddr}, 32'd0);

        // Frame 1: rows 1,0,1,1 and 0,1,1,0
        Start = 1'b1;
        step();
        Start = 1'b0;
        #1;
        chk("fill_ready", {31'd0, PixReady}, 32'd1);
        chk("fill_busy",  {31'd0, Busy},     32'd1);
        push(1'b1); push(1'b0); push(1'b1); push(1'b1);
        PixValid = 1'b0;
        #1;
        chk("r0_load",  {31'd0, Load},      32'd1);
        chk("r0_q",     {28'd0, Q},         32'hD);
        chk("r0_addr",  {31'd0, RowAddr},   32'd0);
        chk("r0_ready", {31'd0, PixReady},  32'd0);
        chk("r0_done",  {31'd0, FrameDone}, 32'd0);
        step();
        chk("gap_ready", {31'd0, PixReady}, 32'd1);
        chk("gap_load",  {31'd0, Load},     32'd0);
        chk("gap_q",     {28'd0, Q},        32'd0);
        chk("gap_addr",  {31'd0, RowAddr},  32'd1);
        push(1'b0); push(1'b1); push(1'b1); push(1'b0);
        PixValid = 1'b0;
        Start    = 1'b1;
        #1;
        chk("r1_load", {31'd0, Load},      32'd1);
        chk("r1_q",    {28'd0, Q},         32'h6);
        chk("r1_addr", {31'd0, RowAddr},   32'd1);
        chk("r1_done", {31'd0, FrameDone}, 32'd0);
        step();
        chk("fd_pulse", {31'd0, FrameDone}, 32'd1);
        chk("fd_load",  {31'd0, Load},      32'd0);
        chk("fd_busy",  {31'd0, Busy},      32'd1);
        chk("fd_q",     {28'd0, Q},         32'h6);
        step();
        Start = 1'b0;
        chk("end_busy", {31'd0, Busy},      32'd0);
        chk("end_done", {31'd0, FrameDone}, 32'd0);
        chk("end_q",    {28'd0, Q},         32'h6);
        chk("end_addr", {31'd0, RowAddr},   32'd1);
        step();
        chk("end_idle", {31'd0, Busy}, 32'd0);

        // Frame 2: 3-cycle PixValid gap after the second pixel
        Start = 1'b1;
        step();
        Start = 1'b0;
        s0 = cycle_cnt;
        push(1'b1); push(1'b0);
        PixValid = 1'b0;
        repeat (3) begin
            #1;
            chk("hold_load",  {31'd0, Load},     32'd0);
            chk("hold_ready", {31'd0, PixReady}, 32'd1);
            step();
        end
        push(1'b1); push(1'b1);
        PixValid = 1'b0;
        #1;
        chk("g_load", {31'd0, Load}, 32'd1);
        chk("g_q",    {28'd0, Q},    32'hD);
        chk("g_lat",  cycle_cnt - s0, 32'd7);

        // Tick held low while in LOAD
        Tick = 1'b0;
        repeat (4) begin
            #1;
            chk("tk_load",  {31'd0, Load},     32'd0);
            chk("tk_q",     {28'd0, Q},        32'hD);
            chk("tk_busy",  {31'd0, Busy},     32'd1);
            chk("tk_ready", {31'd0, PixReady}, 32'd0);
            step();
        end
        Tick = 1'b1;
        #1;
        chk("tk_resume_load", {31'd0, Load},    32'd1);
        chk("tk_resume_q",    {28'd0, Q},       32'hD);
        chk("tk_resume_addr", {31'd0, RowAddr}, 32'd0);
        step();

        // Asynchronous reset two pixels into row 1
        push(1'b1); push(1'b1);
        #2;
        Reset = 1'b0;
        #1;
        chk("ar_busy",  {31'd0, Busy},     32'd0);
        chk("ar_q",     {28'd0, Q},        32'd0);
        chk("ar_addr",  {31'd0, RowAddr},  32'd0);
        chk("ar_load",  {31'd0, Load},     32'd0);
        chk("ar_ready", {31'd0, PixReady}, 32'd0);
        PixValid = 1'b0;
        repeat (3) begin
            step();
            chk("ar_hold_load", {31'd0, Load},      32'd0);
            chk("ar_hold_done", {31'd0, FrameDone}, 32'd0);
        end
        Reset = 1'b1;

        // Frame 3 after reset, with a Tick=0 stall before the first pixel
        Start = 1'b1;
        step();
        Start    = 1'b0;
        Tick     = 1'b0;
        PixValid = 1'b1;
        PixIn    = 1'b0;
        #1;
        chk("stall_ready", {31'd0, PixReady}, 32'd0);
        step();
        Tick = 1'b1;
        push(1'b0); push(1'b1); push(1'b1); push(1'b1);
        PixValid = 1'b0;
        #1;
        chk("f3r0_load", {31'd0, Load},    32'd1);
        chk("f3r0_q",    {28'd0, Q},       32'hE);
        chk("f3r0_addr", {31'd0, RowAddr}, 32'd0);
        step();
        push(1'b1); push(1'b0); push(1'b0); push(1'b1);
        PixValid = 1'b0;
        #1;
        chk("f3r1_load", {31'd0, Load},    32'd1);
        chk("f3r1_q",    {28'd0, Q},       32'h9);
        chk("f3r1_addr", {31'd0, RowAddr}, 32'd1);
        step();
        chk("f3_done",      {31'd0, FrameDone}, 32'd1);
        chk("f3_done_load", {31'd0, Load},      32'd0);
        step();
        chk("f3_idle", {31'd0, Busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
